cond_unit: RTL and testbench

- Downstream consumer of the ALU result flags.
- Holds the architectural NZCV flag register and evaluates the 4-bit ARM condition field of the instruction in execute against it.
- Gates register write, memory write and PC write for that instruction, then presents the gated controls one cycle later, registered toward writeback.
- Sits between the ALU/decoder in execute and the execute/writeback boundary.

---
 rtl/cond_unit_if.sv | 43 ++++
 rtl/cond_unit.sv | 96 +++++++++
 tb/tb_cond_unit.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/cond_unit_if.sv
// Execute-stage bundle between the ALU/decoder and the condition unit.
// Statistics counter signals exist only when COND_STATS_EN is defined.
interface cond_unit_if #(
    parameter int CNT_W = 16
);
    logic       valid_i;
    logic       stall_i;
    logic       flush_i;
    logic [3:0] cond_i;
    logic [1:0] flag_we_i;
    logic [3:0] alu_flags_i;
    logic       reg_we_i;
    logic       mem_we_i;
    logic       pc_src_i;
    logic       cond_ex_o;
    logic [3:0] flags_o;
    logic       valid_o;
    logic       reg_we_o;
    logic       mem_we_o;
    logic       pc_src_o;
`ifdef COND_STATS_EN
    logic [CNT_W-1:0] exec_cnt_o;
    logic [CNT_W-1:0] squash_cnt_o;
`endif

    modport master (
`ifdef COND_STATS_EN
        input  exec_cnt_o, squash_cnt_o,
`endif
        output valid_i, stall_i, flush_i, cond_i, flag_we_i, alu_flags_i,
               reg_we_i, mem_we_i, pc_src_i,
        input  cond_ex_o, flags_o, valid_o, reg_we_o, mem_we_o, pc_src_o
    );

    modport slave (
`ifdef COND_STATS_EN
        output exec_cnt_o, squash_cnt_o,
`endif
        input  valid_i, stall_i, flush_i, cond_i, flag_we_i, alu_flags_i,
               reg_we_i, mem_we_i, pc_src_i,
        output cond_ex_o, flags_o, valid_o, reg_we_o, mem_we_o, pc_src_o
    );
endinterface

// File: rtl/cond_unit.sv
// NZCV flag register plus ARM condition evaluation, gating execute-stage writes
// toward writeback. Define COND_STATS_EN to add executed/squashed counters.
module cond_unit #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000,
    parameter int         CNT_W       = 16
) (
    input  logic        clk,
    input  logic        reset,
    cond_unit_if.slave  bus
);
    logic [3:0] flags;
    logic       cond_ex;
    logic       fire;
    logic       flag_n, flag_z, flag_c, flag_v;

    assign flag_n = flags[0];
    assign flag_z = flags[1];
    assign flag_c = flags[2];
    assign flag_v = flags[3];

    always_comb begin
        cond_ex = 1'b0;
        case (bus.cond_i)
            4'h0: cond_ex = flag_z;
            4'h1: cond_ex = ~flag_z;
            4'h2: cond_ex = flag_c;
            4'h3: cond_ex = ~flag_c;
            4'h4: cond_ex = flag_n;
            4'h5: cond_ex = ~flag_n;
            4'h6: cond_ex = flag_v;
            4'h7: cond_ex = ~flag_v;
            4'h8: cond_ex = flag_c & ~flag_z;
            4'h9: cond_ex = ~flag_c | flag_z;
            4'hA: cond_ex = (flag_n == flag_v);
            4'hB: cond_ex = (flag_n != flag_v);
            4'hC: cond_ex = ~flag_z & (flag_n == flag_v);
            4'hD: cond_ex = flag_z | (flag_n != flag_v);
            4'hE: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign fire          = bus.valid_i & ~bus.stall_i & ~bus.flush_i & cond_ex;
    assign bus.cond_ex_o = cond_ex;
    assign bus.flags_o   = flags;

    // Flush kills the output stage even while stalled; flags only move on fire.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags        <= RESET_FLAGS;
            bus.valid_o  <= 1'b0;
            bus.reg_we_o <= 1'b0;
            bus.mem_we_o <= 1'b0;
            bus.pc_src_o <= 1'b0;
        end else if (bus.flush_i) begin
            bus.valid_o  <= 1'b0;
            bus.reg_we_o <= 1'b0;
            bus.mem_we_o <= 1'b0;
            bus.pc_src_o <= 1'b0;
        end else if (!bus.stall_i) begin
            bus.valid_o  <= bus.valid_i;
            bus.reg_we_o <= bus.valid_i & cond_ex & bus.reg_we_i;
            bus.mem_we_o <= bus.valid_i & cond_ex & bus.mem_we_i;
            bus.pc_src_o <= bus.valid_i & cond_ex & bus.pc_src_i;
            if (fire && bus.flag_we_i[1]) begin
                flags[0] <= bus.alu_flags_i[0];
                flags[1] <= bus.alu_flags_i[1];
            end
            if (fire && bus.flag_we_i[0]) begin
                flags[2] <= bus.alu_flags_i[2];
                flags[3] <= bus.alu_flags_i[3];
            end
        end
    end

`ifdef COND_STATS_EN
    logic [CNT_W-1:0] exec_cnt;
    logic [CNT_W-1:0] squash_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            exec_cnt   <= '0;
            squash_cnt <= '0;
        end else if (bus.valid_i && !bus.stall_i && !bus.flush_i) begin
            if (cond_ex) begin
                exec_cnt <= exec_cnt + 1'b1;
            end else begin
                squash_cnt <= squash_cnt + 1'b1;
            end
        end
    end

    assign bus.exec_cnt_o   = exec_cnt;
    assign bus.squash_cnt_o = squash_cnt;
`endif
endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: expected output-stage values are queued as each
// instruction is driven and compared one clock later.
module tb_cond_unit;
`ifdef COND_STATS_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 16;
`endif

    typedef struct {
        string      tag;
        logic [7:0] outs;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    exp_t sbq[$];

    logic [3:0] mflags;
    logic       mvalid, mreg, mmem, mpc;
    logic [CNT_W-1:0] mexec, msquash;

    cond_unit_if #(.CNT_W(CNT_W)) bus ();

    cond_unit #(.RESET_FLAGS(4'b0000), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference condition: odd codes invert their even partner, E/F special.
    function automatic logic mcond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        n = f[0]; z = f[1]; cf = f[2]; v = f[3];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf & !z;
            3'd5: base = (n == v);
            3'd6: base = !z & (n == v);
            default: base = 1'b1;
        endcase
        if (c[3:1] == 3'd7) return (c[0] == 1'b0);
        return base ^ c[0];
    endfunction

    task automatic checkCond(input string tag, input logic expected);
        checks++;
        assert (bus.cond_ex_o === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, bus.cond_ex_o, expected);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        checks++;
        assert (sbq.size() != 0)
        else begin
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sbq.pop_front();
        checks++;
        assert ({bus.valid_o, bus.reg_we_o, bus.mem_we_o, bus.pc_src_o, bus.flags_o} === e.outs)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", e.tag,
                   {bus.valid_o, bus.reg_we_o, bus.mem_we_o, bus.pc_src_o, bus.flags_o}, e.outs);
        end
    endtask

    // Drive one cycle, predict the registered result, clock it, then compare.
    task automatic applyStimulus(input string tag, input logic rst, input logic v,
                                 input logic st, input logic fl, input logic [3:0] cond,
                                 input logic [1:0] fwe, input logic [3:0] alu,
                                 input logic rw, input logic mw, input logic pc);
        logic ex;
        exp_t e;
        reset           = rst;
        bus.valid_i     = v;
        bus.stall_i     = st;
        bus.flush_i     = fl;
        bus.cond_i      = cond;
        bus.flag_we_i   = fwe;
        bus.alu_flags_i = alu;
        bus.reg_we_i    = rw;
        bus.mem_we_i    = mw;
        bus.pc_src_i    = pc;
        #1;
        if (rst) begin
            mflags = 4'b0000; mvalid = 0; mreg = 0; mmem = 0; mpc = 0;
            mexec = '0; msquash = '0;
        end else begin
            ex = mcond(cond, mflags);
            checkCond({tag, "_condex"}, ex);
            if (fl) begin
                mvalid = 0; mreg = 0; mmem = 0; mpc = 0;
            end else if (!st) begin
                mvalid = v;
                mreg = v & ex & rw;
                mmem = v & ex & mw;
                mpc  = v & ex & pc;
                if (v && ex) begin
                    if (fwe[1]) mflags[1:0] = alu[1:0];
                    if (fwe[0]) mflags[3:2] = alu[3:2];
                    mexec = mexec + 1'b1;
                end else if (v) begin
                    msquash = msquash + 1'b1;
                end
            end
        end
        e.tag  = tag;
        e.outs = {mvalid, mreg, mmem, mpc, mflags};
        sbq.push_back(e);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        checks = 0;
        failures = 0;

        applyStimulus("reset", 1, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
                      2'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

        applyStimulus("set_z", 0, 1, 0, 0, 4'hE, 2'b11, 4'b0010, 0, 0, 0);
        applyStimulus("eq_pass", 0, 1, 0, 0, 4'h0, 2'b00, 4'b0000, 1, 0, 1);
        checkCond("eq_now_fail_ne", 1'b1);
        applyStimulus("ne_squash", 0, 1, 0, 0, 4'h1, 2'b11, 4'b1111, 1, 1, 1);

        applyStimulus("set_n", 0, 1, 0, 0, 4'hE, 2'b11, 4'b0001, 0, 0, 0);
        applyStimulus("lt", 0, 0, 0, 0, 4'hB, 2'b11, 4'b1111, 1, 1, 1);
        checkCond("lt_const", 1'b1);
        bus.cond_i = 4'hA; #1; checkCond("ge_const", 1'b0);
        bus.cond_i = 4'hC; #1; checkCond("gt_const", 1'b0);
        bus.cond_i = 4'hD; #1; checkCond("le_const", 1'b1);
        bus.cond_i = 4'hF; #1; checkCond("nv_const", 1'b0);

        applyStimulus("set_all", 0, 1, 0, 0, 4'hE, 2'b11, 4'b1111, 0, 0, 0);
        applyStimulus("partial_cv", 0, 1, 0, 0, 4'hE, 2'b01, 4'b0000, 0, 0, 0);
        checks++;
        assert (bus.flags_o === 4'b0011)
        else begin
            failures++;
            $error("FAIL partial_const observed=%b expected=0011", bus.flags_o);
        end

        applyStimulus("mem_fire", 0, 1, 0, 0, 4'hE, 2'b00, 4'b0000, 0, 1, 0);
        applyStimulus("stall1", 0, 1, 1, 0, 4'hE, 2'b11, 4'b1100, 0, 1, 0);
        applyStimulus("stall2", 0, 1, 1, 0, 4'hE, 2'b11, 4'b1100, 1, 1, 1);
        applyStimulus("flush_stall", 0, 1, 1, 1, 4'hE, 2'b11, 4'b1100, 1, 1, 1);
        applyStimulus("flush_only", 0, 1, 0, 1, 4'hE, 2'b11, 4'b0101, 1, 1, 1);
        applyStimulus("invalid", 0, 0, 0, 0, 4'hE, 2'b11, 4'b0101, 1, 1, 1);
        applyStimulus("hi_pc", 0, 1, 0, 0, 4'h8, 2'b00, 4'b0000, 0, 0, 1);

        for (int i = 0; i < 40; i++) begin
            applyStimulus("random", 0, 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0),
                          4'($urandom), 2'($urandom), 4'($urandom),
                          1'($urandom), 1'($urandom), 1'($urandom));
        end

`ifdef COND_STATS_EN
        applyStimulus("stats_reset", 1, 0, 0, 0, 4'h0, 2'b00, 4'b0000, 0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            applyStimulus("stats_fire", 0, 1, 0, 0, 4'hE, 2'b00, 4'b0000, 1, 0, 0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus("stats_squash", 0, 1, 0, 0, 4'hF, 2'b00, 4'b0000, 1, 0, 0);
        end
        applyStimulus("stats_stall", 0, 1, 1, 0, 4'hE, 2'b00, 4'b0000, 0, 0, 0);
        applyStimulus("stats_flush", 0, 1, 0, 1, 4'hF, 2'b00, 4'b0000, 0, 0, 0);
        checks++;
        assert (bus.exec_cnt_o === 4'd1)
        else begin
            failures++;
            $error("FAIL exec_cnt observed=%0d expected=1", bus.exec_cnt_o);
        end
        checks++;
        assert (bus.squash_cnt_o === 4'd3)
        else begin
            failures++;
            $error("FAIL squash_cnt observed=%0d expected=3", bus.squash_cnt_o);
        end
`endif

        checks++;
        assert (sbq.size() == 0)
        else begin
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sbq.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
